// File: rtl/mcu_pkg.sv
// Shared opcodes, FSM states and flag bit positions for the accumulator MCU.
package mcu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_HLT = 4'h1;
    localparam logic [3:0] OP_JMP = 4'h2;
    localparam logic [3:0] OP_JZ  = 4'h3;
    localparam logic [3:0] OP_JC  = 4'h4;
    localparam logic [3:0] OP_JS  = 4'h5;
    localparam logic [3:0] OP_JO  = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_ADD = 4'hA;
    localparam logic [3:0] OP_ADC = 4'hB;
    localparam logic [3:0] OP_SUB = 4'hC;
    localparam logic [3:0] OP_AND = 4'hD;
    localparam logic [3:0] OP_OR  = 4'hE;
    localparam logic [3:0] OP_XOR = 4'hF;

    // flags vector is {Z,C,S,O}
    localparam int FLG_Z = 3;
    localparam int FLG_C = 2;
    localparam int FLG_S = 1;
    localparam int FLG_O = 0;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_HALT
    } state_t;

    function automatic logic needs_dr(input logic [3:0] op);
        return (op == OP_LD) || (op >= OP_ADD);
    endfunction

endpackage

// File: rtl/mcu_alu.sv
// Combinational ALU: result and next {Z,C,S,O}; C/O pass through for loads.
module mcu_alu
    import mcu_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [3:0]    i_op,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic [3:0]    i_flags,
    output logic [DW-1:0] o_result,
    output logic [3:0]    o_flags
);
    logic          w_cin;
    logic [DW:0]   w_sum;
    logic [DW:0]   w_diff;

    always_comb begin
        w_cin    = (i_op == OP_ADC) ? i_flags[FLG_C] : 1'b0;
        w_sum    = {1'b0, i_a} + {1'b0, i_b} + {{DW{1'b0}}, w_cin};
        w_diff   = {1'b0, i_a} - {1'b0, i_b};
        o_result = i_b;
        o_flags  = i_flags;
        case (i_op)
            OP_ADD, OP_ADC: begin
                o_result       = w_sum[DW-1:0];
                o_flags[FLG_C] = w_sum[DW];
                o_flags[FLG_O] = (i_a[DW-1] == i_b[DW-1]) && (w_sum[DW-1] != i_a[DW-1]);
            end
            OP_SUB: begin
                // top bit of the widened difference is the borrow
                o_result       = w_diff[DW-1:0];
                o_flags[FLG_C] = w_diff[DW];
                o_flags[FLG_O] = (i_a[DW-1] != i_b[DW-1]) && (w_diff[DW-1] != i_a[DW-1]);
            end
            OP_AND, OP_OR, OP_XOR: begin
                o_result       = (i_op == OP_AND) ? (i_a & i_b) :
                                 (i_op == OP_OR)  ? (i_a | i_b) : (i_a ^ i_b);
                o_flags[FLG_C] = 1'b0;
                o_flags[FLG_O] = 1'b0;
            end
            default: ;
        endcase
        o_flags[FLG_Z] = (o_result == '0);
        o_flags[FLG_S] = o_result[DW-1];
    end

endmodule

// File: rtl/accum_mcu_core.sv
// Accumulator MCU: host loads program memory over valid/ready, then the core
// runs FETCH/DECODE/EXECUTE (3 cycles per instruction), stalled by run_en=0.
module accum_mcu_core
    import mcu_pkg::*;
#(
    parameter int  DW  = 8,
    parameter int  PAW = 8,
    parameter int  DAW = 4,
    localparam int IW  = DW + 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ld_valid,
    output logic           ld_ready,
    input  logic [PAW-1:0] ld_addr,
    input  logic [IW-1:0]  ld_data,
    input  logic           ld_last,
    input  logic           run_en,
    output logic           halted,
    output logic [PAW-1:0] pc,
    output logic [DW-1:0]  acc,
    output logic [3:0]     flags
);
    state_t         r_state;
    logic [PAW-1:0] r_pc;
    logic [DW-1:0]  r_acc;
    logic [3:0]     r_flags;
    logic [IW-1:0]  r_ir;
    logic [DW-1:0]  r_dr;
    logic           r_halted;

    logic [IW-1:0]  r_pm [2**PAW];
    logic [DW-1:0]  r_dm [2**DAW];

    logic [3:0]     w_op;
    logic [DW-1:0]  w_k;
    logic [DW-1:0]  w_alu_b;
    logic [DW-1:0]  w_alu_res;
    logic [3:0]     w_alu_flags;
    logic [PAW-1:0] w_pc_inc;
    logic           w_taken;

    assign w_op     = r_ir[IW-1:IW-4];
    assign w_k      = r_ir[DW-1:0];
    assign w_pc_inc = r_pc + PAW'(1);
    assign w_alu_b  = (w_op == OP_LDI) ? w_k : r_dr;

    always_comb begin
        case (w_op)
            OP_JZ:   w_taken = r_flags[FLG_Z];
            OP_JC:   w_taken = r_flags[FLG_C];
            OP_JS:   w_taken = r_flags[FLG_S];
            OP_JO:   w_taken = r_flags[FLG_O];
            default: w_taken = 1'b0;
        endcase
    end

    mcu_alu #(.DW(DW)) u_alu (
        .i_op     (w_op),
        .i_a      (r_acc),
        .i_b      (w_alu_b),
        .i_flags  (r_flags),
        .o_result (w_alu_res),
        .o_flags  (w_alu_flags)
    );

    always_ff @(posedge clk) begin
        if (!rst && r_state == ST_LOAD && ld_valid)
            r_pm[ld_addr] <= ld_data;
    end

    always_ff @(posedge clk) begin
        if (!rst && r_state == ST_EXECUTE && run_en && w_op == OP_ST)
            r_dm[w_k[DAW-1:0]] <= r_acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_LOAD;
            r_pc     <= '0;
            r_acc    <= '0;
            r_flags  <= '0;
            r_ir     <= '0;
            r_dr     <= '0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (ld_valid && ld_last) begin
                        r_state <= ST_FETCH;
                        r_pc    <= '0;
                        r_acc   <= '0;
                        r_flags <= '0;
                    end
                end
                ST_FETCH: begin
                    if (run_en) begin
                        r_ir    <= r_pm[r_pc];
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (run_en) begin
                        if (needs_dr(w_op))
                            r_dr <= r_dm[r_ir[DAW-1:0]];
                        r_state <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    if (run_en) begin
                        r_state <= ST_FETCH;
                        r_pc    <= w_pc_inc;
                        case (w_op)
                            OP_NOP, OP_ST: ;
                            OP_HLT: begin
                                r_state  <= ST_HALT;
                                r_halted <= 1'b1;
                                r_pc     <= r_pc;
                            end
                            OP_JMP: r_pc <= w_k[PAW-1:0];
                            OP_JZ, OP_JC, OP_JS, OP_JO: begin
                                if (w_taken)
                                    r_pc <= w_k[PAW-1:0];
                            end
                            default: begin
                                r_acc   <= w_alu_res;
                                r_flags <= w_alu_flags;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign ld_ready = (r_state == ST_LOAD);
    assign halted   = r_halted;
    assign pc       = r_pc;
    assign acc      = r_acc;
    assign flags    = r_flags;

endmodule

// File: tb/tb_accum_mcu_core.sv
module tb_accum_mcu_core;

    localparam logic [3:0] NOP = 4'h0, HLT = 4'h1, JMP = 4'h2, JZ = 4'h3, JC = 4'h4, JS = 4'h5;
    localparam logic [3:0] JO = 4'h6, LDI = 4'h7, LD = 4'h8, ST = 4'h9, ADD = 4'hA, ADC = 4'hB;
    localparam logic [3:0] SUB = 4'hC, O_AND = 4'hD, O_OR = 4'hE, O_XOR = 4'hF;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  ld_addr;
    logic [11:0] ld_data;
    logic        ld_last;
    logic        run_en;
    logic        halted;
    logic [7:0]  pc;
    logic [7:0]  acc;
    logic [3:0]  flags;

    int n_chk  = 0;
    int n_fail = 0;

    logic [11:0] img [256];

    typedef struct {
        logic [7:0][11:0] prog;
        logic [7:0]       acc;
        logic [3:0]       flags;
        logic [7:0]       pc;
    } vec_t;

    vec_t tv [15];

    always #5 clk = ~clk;

    accum_mcu_core #(.DW(8), .PAW(8), .DAW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .run_en   (run_en),
        .halted   (halted),
        .pc       (pc),
        .acc      (acc),
        .flags    (flags)
    );

    function automatic logic [11:0] I(input logic [3:0] op, input logic [7:0] k);
        return {op, k};
    endfunction

    function automatic logic [7:0][11:0] P(
        input logic [11:0] w0 = 12'h100, input logic [11:0] w1 = 12'h100,
        input logic [11:0] w2 = 12'h100, input logic [11:0] w3 = 12'h100,
        input logic [11:0] w4 = 12'h100, input logic [11:0] w5 = 12'h100,
        input logic [11:0] w6 = 12'h100, input logic [11:0] w7 = 12'h100);
        logic [7:0][11:0] r;
        r[0] = w0; r[1] = w1; r[2] = w2; r[3] = w3;
        r[4] = w4; r[5] = w5; r[6] = w6; r[7] = w7;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ld_ready"}, 32'(ld_ready), 32'd1);
        chk({tag, "_pc"},       32'(pc),       32'd0);
        chk({tag, "_acc"},      32'(acc),      32'd0);
        chk({tag, "_flags"},    32'(flags),    32'd0);
        chk({tag, "_halted"},   32'(halted),   32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_words(input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ld_valid = 1'b1;
            ld_addr  = i[7:0];
            ld_data  = img[i];
            ld_last  = with_last && (i == n - 1);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int c = 0;
        while (!halted && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_halt_reached"}, 32'(halted), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; ld_addr = '0; ld_data = '0; run_en = 1'b1;

        tv[0]  = '{P(I(LDI,8'h7F), I(ST,8'd2), I(ADD,8'd2), I(HLT,0)), 8'hFE, 4'b0011, 8'd3};
        tv[1]  = '{P(I(LDI,8'hFF), I(ST,8'd0), I(ADD,8'd0), I(HLT,0)), 8'hFE, 4'b0110, 8'd3};
        tv[2]  = '{P(I(LDI,8'hFF), I(ST,8'd0), I(ADD,8'd0), I(ADC,8'd0), I(HLT,0)), 8'hFE, 4'b0110, 8'd4};
        tv[3]  = '{P(I(LDI,8'h00), I(JZ,8'd5)), 8'h00, 4'b1000, 8'd5};
        tv[4]  = '{P(I(LDI,8'h01), I(JZ,8'd5)), 8'h01, 4'b0000, 8'd2};
        tv[5]  = '{P(I(LDI,8'h05), I(ST,8'd1), I(LDI,8'h03), I(SUB,8'd1)), 8'hFE, 4'b0110, 8'd4};
        tv[6]  = '{P(I(LDI,8'h01), I(ST,8'd1), I(LDI,8'h80), I(SUB,8'd1)), 8'h7F, 4'b0001, 8'd4};
        tv[7]  = '{P(I(LDI,8'h42), I(ST,8'd3), I(SUB,8'd3)), 8'h00, 4'b1000, 8'd3};
        tv[8]  = '{P(I(LDI,8'hFF), I(ST,8'd4), I(ADD,8'd4), I(O_AND,8'd4)), 8'hFE, 4'b0010, 8'd4};
        tv[9]  = '{P(I(LDI,8'h0F), I(ST,8'd5), I(LDI,8'h3C), I(O_OR,8'd5), I(O_XOR,8'd5)), 8'h30, 4'b0000, 8'd5};
        tv[10] = '{P(I(LDI,8'h5A), I(ST,8'd6), I(LDI,8'h00), I(LD,8'd6)), 8'h5A, 4'b0000, 8'd4};
        tv[11] = '{P(I(LDI,8'hFF), I(ST,8'd0), I(ADD,8'd0), I(JC,8'd6)), 8'hFE, 4'b0110, 8'd6};
        tv[12] = '{P(I(LDI,8'h7F), I(ST,8'd2), I(ADD,8'd2), I(JO,8'd6)), 8'hFE, 4'b0011, 8'd6};
        tv[13] = '{P(I(LDI,8'h80), I(JS,8'd3)), 8'h80, 4'b0010, 8'd3};
        tv[14] = '{P(I(JMP,8'd3), I(HLT,0), I(HLT,0), I(LDI,8'h11)), 8'h11, 4'b0000, 8'd4};

        @(negedge clk);
        @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;

        // three-word load, first fetch must come from PM[0]
        img[0] = I(LDI, 8'h33); img[1] = I(HLT, 0); img[2] = I(NOP, 0);
        load_words(3, 1'b1);
        chk("load3_ld_ready_drop", 32'(ld_ready), 32'd0);
        chk("load3_pc_start", 32'(pc), 32'd0);
        wait_halt("load3", 50);
        chk("load3_acc", 32'(acc), 32'h33);
        chk("load3_pc", 32'(pc), 32'd1);

        for (int i = 0; i < 15; i++) begin
            do_reset();
            for (int j = 0; j < 8; j++) img[j] = tv[i].prog[j];
            load_words(8, 1'b1);
            wait_halt($sformatf("v%0d", i), 200);
            chk($sformatf("v%0d_acc", i),   32'(acc),   32'(tv[i].acc));
            chk($sformatf("v%0d_flags", i), 32'(flags), 32'(tv[i].flags));
            chk($sformatf("v%0d_pc", i),    32'(pc),    32'(tv[i].pc));
        end

        // reset out of HALT
        do_reset();
        chk_reset_state("halt_rst");

        // reset in the middle of a load, then a fresh load still works
        img[0] = I(LDI, 8'h99); img[1] = I(HLT, 0);
        load_words(2, 1'b0);
        chk("midload_still_loading", 32'(ld_ready), 32'd1);
        do_reset();
        chk_reset_state("midload_rst");
        img[0] = I(LDI, 8'h21); img[1] = I(HLT, 0);
        load_words(2, 1'b1);
        wait_halt("after_midload", 50);
        chk("after_midload_acc", 32'(acc), 32'h21);

        // stall during EXECUTE of ADD (ninth edge after the load)
        do_reset();
        img[0] = I(LDI, 8'h7F); img[1] = I(ST, 8'd2); img[2] = I(ADD, 8'd2); img[3] = I(HLT, 0);
        load_words(4, 1'b1);
        repeat (8) @(negedge clk);
        run_en = 1'b0;
        repeat (10) @(negedge clk);
        chk("stall_pc", 32'(pc), 32'd2);
        chk("stall_acc", 32'(acc), 32'h7F);
        chk("stall_flags", 32'(flags), 32'd0);
        chk("stall_halted", 32'(halted), 32'd0);
        run_en = 1'b1;
        wait_halt("stall", 50);
        chk("stall_resume_acc", 32'(acc), 32'hFE);
        chk("stall_resume_flags", 32'(flags), 32'b0011);
        chk("stall_resume_pc", 32'(pc), 32'd3);

        // reach PM[255] by fallthrough; first with JMP 0 there, then with plain wrap
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            for (int j = 0; j < 256; j++) img[j] = I(NOP, 0);
            img[0] = I(JS, 8'd4); img[1] = I(LDI, 8'h80); img[2] = I(JMP, 8'd5); img[4] = I(HLT, 0);
            img[255] = (pass == 0) ? I(JMP, 8'd0) : I(NOP, 0);
            load_words(256, 1'b1);
            wait_halt($sformatf("wrap%0d", pass), 1200);
            chk($sformatf("wrap%0d_pc", pass), 32'(pc), 32'd4);
            chk($sformatf("wrap%0d_acc", pass), 32'(acc), 32'h80);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
